// File: rtl/sram_emulator_pkg.sv
// Shared types and pin-level constants for the on-chip SRAM emulator.
// Strobe bit positions follow the controller's {UB_N, LB_N, WE_N, CE_N, OE_N} ordering.
package sram_pkg;

    localparam int SRAM_DATA_W = 16;
    localparam int SRAM_ADDR_W = 18;

    localparam int UB_N_BIT = 4;
    localparam int LB_N_BIT = 3;
    localparam int WE_N_BIT = 2;
    localparam int CE_N_BIT = 1;
    localparam int OE_N_BIT = 0;

    typedef enum logic [2:0] {
        CLEAR      = 3'd0,
        IDLE       = 3'd1,
        READ_WAIT  = 3'd2,
        READ_VALID = 3'd3,
        WRITE      = 3'd4
    } sram_state_t;

endpackage

// File: rtl/sram_emulator_if.sv
// Address and strobe pins from the SRAM controller to the emulator.
// The shared data bus is a separate tristate port on the emulator.
interface sram_emulator_if;
    import sram_pkg::*;

    logic [SRAM_ADDR_W-1:0] sramAddress;
    logic [4:0]             sramCtrl;

    modport master (output sramAddress, output sramCtrl);
    modport slave  (input  sramAddress, input  sramCtrl);

endinterface

// File: rtl/sram_byte_lane_ram.sv
// Single-port word RAM with per-byte write enables and an enabled synchronous read.
// The read port only updates when re is high, so rdata doubles as a holding register.
module sram_byte_lane_ram
    import sram_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                   clk,
    input  logic [DEPTH_LOG2-1:0]  addr,
    input  logic [1:0]             we,
    input  logic                   re,
    input  logic [SRAM_DATA_W-1:0] wdata,
    output logic [SRAM_DATA_W-1:0] rdata
);

    logic [SRAM_DATA_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we[0]) mem[addr][7:0]  <= wdata[7:0];
        if (we[1]) mem[addr][15:8] <= wdata[15:8];
        if (re)    rdata           <= mem[addr];
    end

endmodule

// File: rtl/sram_emulator.sv
// Pin-level responder that stands in for an external 16-bit async SRAM.
// Clears the array after reset, then serves byte-laned writes and latency-delayed reads.
module sram_emulator
    import sram_pkg::*;
#(
    parameter int DEPTH_LOG2   = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_emulator_if.slave         bus,
    inout  wire [SRAM_DATA_W-1:0]  sramData,
    output logic                   initDone,
    output logic [15:0]            readCount,
    output logic [15:0]            writeCount,
    output sram_state_t            state_dbg,
    output logic                   drive_dbg
);

    sram_state_t             state, state_nxt;
    logic [DEPTH_LOG2-1:0]   clear_ptr, clear_ptr_nxt;
    logic [2:0]              cnt, cnt_nxt;
    logic [DEPTH_LOG2-1:0]   rd_addr, rd_addr_nxt;
    logic [DEPTH_LOG2-1:0]   wr_addr, wr_addr_nxt;
    logic [SRAM_DATA_W-1:0]  wr_data, wr_data_nxt;
    logic [1:0]              wr_be, wr_be_nxt;
    logic                    init_nxt, rd_inc, wr_inc, rd_loaded;

    logic [DEPTH_LOG2-1:0]   ram_addr;
    logic [1:0]              ram_we;
    logic                    ram_re;
    logic [SRAM_DATA_W-1:0]  ram_wdata, ram_rdata, rd_data;

    logic [DEPTH_LOG2-1:0]   pin_addr;
    logic                    sel, wr_cond, rd_cond, drive;
    logic                    unused_addr_bits;

    // Upper address bits alias onto the implemented depth.
    assign pin_addr         = bus.sramAddress[DEPTH_LOG2-1:0];
    assign unused_addr_bits = ^bus.sramAddress[SRAM_ADDR_W-1:DEPTH_LOG2];

    assign sel     = ~bus.sramCtrl[CE_N_BIT];
    assign wr_cond = sel & ~bus.sramCtrl[WE_N_BIT];
    assign rd_cond = sel &  bus.sramCtrl[WE_N_BIT] & ~bus.sramCtrl[OE_N_BIT];

    // Until the first array read after reset the read register reads as zero.
    assign rd_data   = rd_loaded ? ram_rdata : '0;
    assign drive     = ((state == READ_WAIT) || (state == READ_VALID)) && rd_cond;
    assign sramData  = drive ? rd_data : 'z;
    assign state_dbg = state;
    assign drive_dbg = drive;

    always_comb begin
        state_nxt     = state;
        clear_ptr_nxt = clear_ptr;
        cnt_nxt       = cnt;
        rd_addr_nxt   = rd_addr;
        wr_addr_nxt   = wr_addr;
        wr_data_nxt   = wr_data;
        wr_be_nxt     = wr_be;
        init_nxt      = initDone;
        rd_inc        = 1'b0;
        wr_inc        = 1'b0;
        ram_addr      = rd_addr;
        ram_we        = 2'b00;
        ram_re        = 1'b0;
        ram_wdata     = wr_data;

        unique case (state)
            CLEAR: begin
                ram_addr      = clear_ptr;
                ram_we        = 2'b11;
                ram_wdata     = '0;
                clear_ptr_nxt = clear_ptr + 1'b1;
                if (clear_ptr == '1) begin
                    state_nxt = IDLE;
                    init_nxt  = 1'b1;
                end
            end
            IDLE: begin
                if (rd_cond) begin
                    state_nxt   = READ_WAIT;
                    rd_addr_nxt = pin_addr;
                    cnt_nxt     = 3'd1;
                end else if (wr_cond) begin
                    state_nxt   = WRITE;
                    wr_addr_nxt = pin_addr;
                    wr_data_nxt = sramData;
                    wr_be_nxt   = {~bus.sramCtrl[UB_N_BIT], ~bus.sramCtrl[LB_N_BIT]};
                end
            end
            READ_WAIT: begin
                if (!rd_cond) begin
                    state_nxt = IDLE;
                end else if (pin_addr != rd_addr) begin
                    rd_addr_nxt = pin_addr;
                    cnt_nxt     = 3'd1;
                end else if (cnt == 3'(READ_LATENCY)) begin
                    ram_re    = 1'b1;
                    state_nxt = READ_VALID;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            READ_VALID: begin
                if (!rd_cond) begin
                    state_nxt = IDLE;
                    rd_inc    = 1'b1;
                end else if (pin_addr != rd_addr) begin
                    state_nxt   = READ_WAIT;
                    rd_addr_nxt = pin_addr;
                    cnt_nxt     = 3'd1;
                end
            end
            WRITE: begin
                if (wr_cond) begin
                    wr_addr_nxt = pin_addr;
                    wr_data_nxt = sramData;
                    wr_be_nxt   = {~bus.sramCtrl[UB_N_BIT], ~bus.sramCtrl[LB_N_BIT]};
                end else begin
                    // Commit the last captured beat on the strobe's rising side.
                    ram_addr = wr_addr;
                    ram_we   = wr_be;
                    wr_inc   = 1'b1;
                    if (rd_cond) begin
                        state_nxt   = READ_WAIT;
                        rd_addr_nxt = pin_addr;
                        cnt_nxt     = 3'd1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= CLEAR;
            clear_ptr  <= '0;
            cnt        <= '0;
            rd_addr    <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_be      <= '0;
            initDone   <= 1'b0;
            readCount  <= '0;
            writeCount <= '0;
            rd_loaded  <= 1'b0;
        end else begin
            state     <= state_nxt;
            clear_ptr <= clear_ptr_nxt;
            cnt       <= cnt_nxt;
            rd_addr   <= rd_addr_nxt;
            wr_addr   <= wr_addr_nxt;
            wr_data   <= wr_data_nxt;
            wr_be     <= wr_be_nxt;
            initDone  <= init_nxt;
            if (ram_re)                          rd_loaded  <= 1'b1;
            if (rd_inc && (readCount != '1))     readCount  <= readCount + 16'd1;
            if (wr_inc && (writeCount != '1))    writeCount <= writeCount + 16'd1;
        end
    end

    sram_byte_lane_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .re    (ram_re),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: doc/sram_emulator.md
Name: sram_emulator

Overview:
- Synthesizable responder for the external 16-bit asynchronous SRAM pin interface driven by the memory stage's SRAM controller.
- Replaces the off-chip 256K x 16 SRAM with on-chip RAM, for FPGA builds without external SRAM and for closed-loop simulation of the memory stage.
- Decodes the pin-level strobes, performs byte-laned writes and returns read data on the shared bidirectional bus after a programmable latency.
- Clears its array after reset.

Parameters:
- DEPTH_LOG2, 10, log2 of word count; sramAddress bits above this are ignored (aliasing).
- READ_LATENCY, 2, clocks from a stable read address to valid data on sramData (range 1..7).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- sramData  inout  16  shared data bus.
- sramAddress  in  18  word address.
- sramCtrl  in  5  active-low strobes {UB_N, LB_N, WE_N, CE_N, OE_N}, bit 4 down to bit 0.
- initDone  out  1  array clear complete.
- readCount  out  16  completed reads, saturating at 16'hFFFF.
- writeCount  out  16  committed writes, saturating at 16'hFFFF.

Behaviour:
- Reset values (rst low, asynchronous):
  - state = CLEAR, clearPtr = 0, latency counter = 0, read register = 0.
  - initDone = 0, readCount = 0, writeCount = 0.
  - sramData tri-stated.
- Clocking: all logic on clk rising edge; no combinational path from sramData to sramData.
- Mid-operation reset: aborts any access; a partially written word is discarded; CLEAR restarts from 0.
- States: CLEAR, IDLE, READ_WAIT, READ_VALID, WRITE.
- CLEAR:
  - Writes 16'h0000 to word clearPtr each cycle; clearPtr increments.
  - After word 2^DEPTH_LOG2-1, go to IDLE and set initDone = 1, which stays 1 until reset.
  - All pin activity is ignored and the bus is not driven during CLEAR.
- Decode (sampled each clock, strobes active-low):
  - Selected = CE_N = 0.
  - Write = selected and WE_N = 0. WE_N = 0 has priority over OE_N, and the emulator never drives the bus while WE_N = 0.
  - Read = selected, WE_N = 1 and OE_N = 0.
- IDLE:
  - Read: go to READ_WAIT; latch word address addr[DEPTH_LOG2-1:0]; counter = 1.
  - Write: go to WRITE.
  - Otherwise stay in IDLE.
- READ_WAIT:
  - If the address changes or the read condition drops, restart: counter = 1 on a new address, or return to IDLE.
  - Else counter increments. When counter = READ_LATENCY, load the read register from the array and go to READ_VALID.
- READ_VALID:
  - Holds the read register.
  - Address change: go to READ_WAIT with a new latch.
  - Read condition dropped: go to IDLE and increment readCount once.
  - A read held for multiple cycles counts once.
- Bus drive (combinational from state and pins):
  - sramData = read register only while state is READ_WAIT or READ_VALID, CE_N = 0, OE_N = 0 and WE_N = 1; otherwise 16'hZZZZ.
  - During READ_WAIT the bus carries the previous read value and is not valid.
- WRITE:
  - Each cycle while the write condition holds, capture address, data and byte enables.
  - Commit occurs on the first cycle WE_N = 1 or CE_N = 1: upper byte written if UB_N was 0, lower byte if LB_N was 0, using the last captured values. writeCount increments.
  - If both UB_N and LB_N were 1, no array change, but writeCount still increments.
  - After commit: go to READ_WAIT if the read condition now holds, else IDLE.
- Counter overflow: readCount and writeCount saturate at 16'hFFFF and do not wrap.
- Address aliasing: the address is masked to the low DEPTH_LOG2 bits, so 18'h00400 aliases 18'h00000 at the default depth.

Decomposition:
- Shared package sram_pkg:
  - State enum.
  - sramCtrl bit indices UB_N_BIT = 4, LB_N_BIT = 3, WE_N_BIT = 2, CE_N_BIT = 1, OE_N_BIT = 0.
  - SRAM_DATA_W = 16, SRAM_ADDR_W = 18.
- Sub-module sram_byte_lane_ram: 2^DEPTH_LOG2 x 16 single-port RAM with 2-bit byte write enable and synchronous read; no reset.

Test Plan:
- Reset release, sramCtrl = 5'b11111 -> initDone rises exactly 1024 cycles after rst goes high; bus stays Z; reading addr 18'h003FF returns 16'h0000.
- Write 16'hBEEF to addr 18'h00010 (WE_N low 3 cycles, UB_N = LB_N = 0), then read -> sramData = 16'hBEEF exactly 2 cycles after OE_N falls; writeCount = 1, readCount = 1 after OE_N rises.
- Byte lanes: write 16'h1234 to addr 5, then write 16'hAB00 to addr 5 with LB_N = 1 -> read returns 16'hAB34.
- WE_N = 0 and OE_N = 0 together at addr 7 with data 16'h5A5A -> bus never driven by the emulator; a later read of addr 7 returns 16'h5A5A.
- Address change mid-read from 3 to 4 in cycle 1 of READ_WAIT -> latency restarts; data of addr 4 appears 2 cycles after the change; readCount increments by 1.
- Assert rst during a write pulse with data 16'hFFFF to addr 2 -> sramData goes Z immediately, CLEAR reruns, and addr 2 reads 16'h0000.
